// File: rtl/gol_generation_scheduler_if.sv
// Row-update handshake between the generation scheduler and the cell-update engine.
// The scheduler is the master (requests rows); the engine is the slave (acknowledges them).
interface gol_generation_scheduler_if #(
  parameter int GRID_H = 30
);
  localparam int IDX_W = $clog2(GRID_H);

  logic             rowReq;
  logic [IDX_W-1:0] rowIdx;
  logic             rowClear;
  logic             rowDone;

  modport master (
    output rowReq,
    output rowIdx,
    output rowClear,
    input  rowDone
  );

  modport slave (
    input  rowReq,
    input  rowIdx,
    input  rowClear,
    output rowDone
  );
endinterface

// File: rtl/gol_generation_scheduler.sv
// Game of Life generation sequencer: starts run/step/clear sweeps, walks rows through the
// update engine, then flips the front/back buffer select on the next frame boundary.
module gol_generation_scheduler #(
  parameter int GRID_H         = 30,
  parameter int FRAMES_PER_GEN = 30,
  parameter int GEN_W          = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           frameTick,
  input  logic                           runEn,
  input  logic                           stepReq,
  input  logic                           clearReq,
  gol_generation_scheduler_if.master     row,
  output logic                           bufSel,
  output logic [GEN_W-1:0]               genCount,
  output logic                           busy
);

  localparam int IDX_W = $clog2(GRID_H);
  localparam int DIV_W = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;

  localparam logic [IDX_W-1:0] LAST_ROW   = IDX_W'(GRID_H - 1);
  localparam logic [DIV_W-1:0] LAST_FRAME = DIV_W'(FRAMES_PER_GEN - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SWEEP     = 2'd1,
    SWAP_WAIT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             req_q, req_d;
  logic             clr_q, clr_d;
  logic             was_clr_q, was_clr_d;
  logic             buf_q, buf_d;
  logic             busy_q, busy_d;
  logic             step_p_q, step_p_d;
  logic             clr_p_q, clr_p_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             run_trig;

  // Frame divider: only counts while running, so re-enabling always waits a full period.
  always_comb begin
    div_d    = div_q;
    run_trig = 1'b0;
    if (!runEn) begin
      div_d = '0;
    end else if (frameTick) begin
      if (div_q == LAST_FRAME) begin
        div_d    = '0;
        run_trig = 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    req_d     = req_q;
    clr_d     = clr_q;
    was_clr_d = was_clr_q;
    buf_d     = buf_q;
    gen_d     = gen_q;
    busy_d    = busy_q;
    // A pulse arriving while IDLE is seen in the same cycle, so it starts without extra latency.
    step_p_d  = step_p_q | stepReq;
    clr_p_d   = clr_p_q | clearReq;

    unique case (state_q)
      IDLE: begin
        if (clr_p_d) begin
          state_d   = SWEEP;
          req_d     = 1'b1;
          idx_d     = '0;
          clr_d     = 1'b1;
          was_clr_d = 1'b1;
          busy_d    = 1'b1;
          clr_p_d   = 1'b0;
          step_p_d  = 1'b0;
        end else if (step_p_d || run_trig) begin
          state_d   = SWEEP;
          req_d     = 1'b1;
          idx_d     = '0;
          clr_d     = 1'b0;
          was_clr_d = 1'b0;
          busy_d    = 1'b1;
          step_p_d  = 1'b0;
        end
      end

      SWEEP: begin
        if (req_q && row.rowDone) begin
          if (idx_q == LAST_ROW) begin
            state_d = SWAP_WAIT;
            req_d   = 1'b0;
            idx_d   = '0;
            clr_d   = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      SWAP_WAIT: begin
        // State is registered, so a tick coinciding with entry is never seen here.
        if (frameTick) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          buf_d   = ~buf_q;
          gen_d   = was_clr_q ? '0 : gen_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        clr_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      req_q     <= 1'b0;
      clr_q     <= 1'b0;
      was_clr_q <= 1'b0;
      buf_q     <= 1'b0;
      gen_q     <= '0;
      busy_q    <= 1'b0;
      step_p_q  <= 1'b0;
      clr_p_q   <= 1'b0;
      div_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      req_q     <= req_d;
      clr_q     <= clr_d;
      was_clr_q <= was_clr_d;
      buf_q     <= buf_d;
      gen_q     <= gen_d;
      busy_q    <= busy_d;
      step_p_q  <= step_p_d;
      clr_p_q   <= clr_p_d;
      div_q     <= div_d;
    end
  end

  assign row.rowReq   = req_q;
  assign row.rowIdx   = idx_q;
  assign row.rowClear = clr_q;
  assign bufSel       = buf_q;
  assign genCount     = gen_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_gol_generation_scheduler.sv
// Directed bench for gol_generation_scheduler with GRID_H=4, FRAMES_PER_GEN=3.
module tb_gol_generation_scheduler;

  localparam int GRID_H = 4;
  localparam int FPG    = 3;
  localparam int GEN_W  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frameTick = 1'b0;
  logic runEn = 1'b0;
  logic stepReq = 1'b0;
  logic clearReq = 1'b0;
  logic bufSel;
  logic [GEN_W-1:0] genCount;
  logic busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  gol_generation_scheduler_if #(.GRID_H(GRID_H)) row_if ();

  gol_generation_scheduler #(
    .GRID_H(GRID_H),
    .FRAMES_PER_GEN(FPG),
    .GEN_W(GEN_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .frameTick(frameTick),
    .runEn(runEn),
    .stepReq(stepReq),
    .clearReq(clearReq),
    .row(row_if.master),
    .bufSel(bufSel),
    .genCount(genCount),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ft, run, step, clr, done;
    logic e_req;
    int   e_idx;
    logic e_clr, e_buf;
    int   e_gen;
    logic e_busy;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input logic ft, run, step, clr, done,
                              input logic e_req, input int e_idx,
                              input logic e_clr, e_buf, input int e_gen,
                              input logic e_busy);
    vec_t v;
    v.ft = ft; v.run = run; v.step = step; v.clr = clr; v.done = done;
    v.e_req = e_req; v.e_idx = e_idx; v.e_clr = e_clr; v.e_buf = e_buf;
    v.e_gen = e_gen; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic chk_all(input string tag, input int req, idx, clr, bsel, gen, bsy);
    chk({tag, ".rowReq"},   int'(row_if.rowReq),   req);
    chk({tag, ".rowIdx"},   int'(row_if.rowIdx),   idx);
    chk({tag, ".rowClear"}, int'(row_if.rowClear), clr);
    chk({tag, ".bufSel"},   int'(bufSel),          bsel);
    chk({tag, ".genCount"}, int'(genCount),        gen);
    chk({tag, ".busy"},     int'(busy),            bsy);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic tick();
    frameTick = 1'b1;
    cyc();
    frameTick = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    int exp_gen;
    row_if.rowDone = 1'b0;

    // ft run step clr done | req idx clr buf gen busy
    vecs[0]  = mk(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 1, 0, 0,  1, 0, 0, 0, 0, 1);
    vecs[2]  = mk(0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 1);
    vecs[3]  = mk(0, 0, 0, 0, 1,  1, 1, 0, 0, 0, 1);
    vecs[4]  = mk(0, 0, 0, 0, 1,  1, 2, 0, 0, 0, 1);
    vecs[5]  = mk(0, 0, 0, 0, 1,  1, 3, 0, 0, 0, 1);
    vecs[6]  = mk(0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1);
    vecs[7]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
    vecs[8]  = mk(1, 0, 0, 0, 0,  0, 0, 0, 1, 1, 0);
    vecs[9]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 0);
    vecs[10] = mk(0, 0, 1, 1, 0,  1, 0, 1, 1, 1, 1);
    vecs[11] = mk(0, 0, 0, 0, 1,  1, 1, 1, 1, 1, 1);
    vecs[12] = mk(0, 0, 0, 0, 1,  1, 2, 1, 1, 1, 1);
    vecs[13] = mk(0, 0, 0, 0, 1,  1, 3, 1, 1, 1, 1);
    vecs[14] = mk(1, 0, 0, 0, 1,  0, 0, 0, 1, 1, 1);
    vecs[15] = mk(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    vecs[16] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    vecs[17] = mk(0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);

    do_reset();
    chk_all("reset", 0, 0, 0, 0, 0, 0);

    // Step sweep, entry-cycle tick ignored, clear+step collapse to a single clear sweep.
    for (int i = 0; i < 18; i++) begin
      frameTick = vecs[i].ft;
      runEn     = vecs[i].run;
      stepReq   = vecs[i].step;
      clearReq  = vecs[i].clr;
      row_if.rowDone = vecs[i].done;
      cyc();
      chk_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_idx, vecs[i].e_clr,
              vecs[i].e_buf, vecs[i].e_gen, vecs[i].e_busy);
    end
    frameTick = 0; stepReq = 0; clearReq = 0; row_if.rowDone = 1'b0;

    // Free-run with an instantly acknowledging engine.
    runEn = 1'b1;
    row_if.rowDone = 1'b1;
    idle_cycles(2);
    for (int t = 1; t <= 10; t++) begin
      tick();
      exp_gen = int'(t >= 4) + int'(t >= 7) + int'(t >= 10);
      chk($sformatf("run.t%0d.busy", t), int'(busy), int'(t % 3 == 0));
      chk($sformatf("run.t%0d.rowReq", t), int'(row_if.rowReq), int'(t % 3 == 0));
      chk($sformatf("run.t%0d.genCount", t), int'(genCount), exp_gen);
      chk($sformatf("run.t%0d.bufSel", t), int'(bufSel), exp_gen % 2);
      idle_cycles(7);
    end
    runEn = 1'b0;
    row_if.rowDone = 1'b0;

    // Clear request during a run sweep.
    do_reset();
    runEn = 1'b1;
    idle_cycles(1);
    for (int t = 1; t <= 3; t++) begin
      tick();
      idle_cycles(3);
    end
    chk_all("crun.start", 1, 0, 0, 0, 0, 1);
    row_if.rowDone = 1'b1; cyc();
    row_if.rowDone = 1'b0; clearReq = 1'b1; cyc();
    clearReq = 1'b0;
    chk_all("crun.midclr", 1, 1, 0, 0, 0, 1);
    row_if.rowDone = 1'b1;
    idle_cycles(3);
    row_if.rowDone = 1'b0;
    chk_all("crun.swapwait", 0, 0, 0, 0, 0, 1);
    tick();
    chk_all("crun.swap", 0, 0, 0, 1, 1, 0);
    cyc();
    chk_all("clr.start", 1, 0, 1, 1, 1, 1);
    for (int r = 0; r < GRID_H; r++) begin
      row_if.rowDone = 1'b1;
      cyc();
      if (r < GRID_H - 1) chk_all($sformatf("clr.r%0d", r), 1, r + 1, 1, 1, 1, 1);
      else                chk_all("clr.end", 0, 0, 0, 1, 1, 1);
    end
    row_if.rowDone = 1'b0;
    tick();
    chk_all("clr.swap", 0, 0, 0, 0, 0, 0);
    cyc();
    chk_all("clr.after", 0, 0, 0, 0, 0, 0);
    runEn = 1'b0;

    // Engine stall on row 2 with frame ticks arriving mid-sweep.
    stepReq = 1'b1; cyc(); stepReq = 1'b0;
    row_if.rowDone = 1'b1; idle_cycles(2); row_if.rowDone = 1'b0;
    for (int i = 0; i < 100; i++) begin
      frameTick = (i % 20 == 5);
      cyc();
      chk($sformatf("stall%0d.rowReq", i), int'(row_if.rowReq), 1);
      chk($sformatf("stall%0d.rowIdx", i), int'(row_if.rowIdx), 2);
      chk($sformatf("stall%0d.bufSel", i), int'(bufSel), 0);
    end
    frameTick = 1'b0;
    chk_all("stall.end", 1, 2, 0, 0, 0, 1);
    row_if.rowDone = 1'b1; idle_cycles(2); row_if.rowDone = 1'b0;
    chk_all("stall.swapwait", 0, 0, 0, 0, 0, 1);
    tick();
    chk_all("stall.swap", 0, 0, 0, 1, 1, 0);

    // Reset in the middle of a sweep abandons it without a swap.
    stepReq = 1'b1; cyc(); stepReq = 1'b0;
    row_if.rowDone = 1'b1; cyc(); row_if.rowDone = 1'b0;
    chk_all("rstmid.pre", 1, 1, 0, 1, 1, 1);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk_all("rstmid", 0, 0, 0, 0, 0, 0);
    idle_cycles(3);
    chk_all("rstmid.idle", 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
